// File: rtl/sisc_fetch_pkg.sv
// sisc_pkg: shared definitions for the SISC fetch front end.
// Holds the major opcode map, the fetch FSM state type and the
// prefetch-queue entry layout for the default 16-bit PC / 32-bit word build.
package sisc_pkg;

    localparam int FETCH_AW = 16;
    localparam int FETCH_DW = 32;

    // Major opcodes, found in instr[DW-1:DW-4].
    localparam logic [3:0] OP_ALU  = 4'h0;
    localparam logic [3:0] OP_ALUI = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_BRA  = 4'hC;
    localparam logic [3:0] OP_BCC  = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_SYS  = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_AW-1:0] pc;
        logic [FETCH_DW-1:0] instr;
    } fetch_entry_t;

    // Unconditional relative branch: OP_BRA with a zero condition field.
    function automatic logic is_uncond_bra(input logic [3:0] op, input logic [3:0] cond);
        return (op == OP_BRA) && (cond == 4'h0);
    endfunction

endpackage

// File: rtl/sisc_fetch_if.sv
// sisc_fetch_if: instruction-memory, decode and redirect signals of the
// fetch front end. The master modport is the fetch unit.
//
// Handshakes:
//   imem: req/addr are held by the fetch unit until a cycle with ack=1;
//         ack is only meaningful while req=1 and rdata is valid in that cycle.
//   decode: the head entry transfers on a rising edge where
//         instr_valid=1 and instr_ready=1; instr/instr_pc are meaningless
//         while instr_valid=0.
//   redirect: single-cycle strobe, redirect_addr sampled with it.
import sisc_pkg::*;

interface sisc_fetch_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [DW-1:0] imem_rdata;
    logic          instr_valid;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;
    logic          redirect;
    logic [AW-1:0] redirect_addr;
    fetch_state_t  dbg_state;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, dbg_state,
        input  imem_ack, imem_rdata, instr_ready, redirect, redirect_addr
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, dbg_state,
        output imem_ack, imem_rdata, instr_ready, redirect, redirect_addr
    );
endinterface

// File: rtl/sisc_fetch_q.sv
// sisc_fetch_q: synchronous FIFO with flush and occupancy count.
// Head data comes straight from the storage array addressed by a registered
// read pointer, so it is valid the cycle after the write.
module sisc_fetch_q #(
    parameter int DEPTH = 4,
    parameter int W     = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Pops on an empty queue are ignored; a push into a full queue only
    // lands when the head leaves in the same cycle.
    assign do_pop  = pop & (count != '0);
    assign do_push = push & ((count != CW'(DEPTH)) | do_pop);

    assign rdata = mem[rd_ptr];
    assign valid = (count != '0);

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap modulo DEPTH; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/sisc_fetch.sv
// sisc_fetch: SISC instruction-fetch front end. Issues one word read at a
// time, buffers returned words with their PCs, and flushes on redirect.
// Optional macro SISC_FETCH_BRPRED_EN: predecode unconditional relative
// branches on capture and continue fetching at their target.
import sisc_pkg::*;

module sisc_fetch #(
    parameter int            AW      = 16,
    parameter int            DW      = 32,
    parameter int            DEPTH   = 4,
    parameter logic [AW-1:0] RST_VEC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    sisc_fetch_if.master           bus,
    output logic [$clog2(DEPTH):0] q_count
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t     state;
    fetch_state_t     state_nxt;
    logic [AW-1:0]    fetch_pc;
    logic [AW-1:0]    fetch_pc_nxt;
    logic [AW-1:0]    addr_q;
    logic [AW-1:0]    addr_nxt;
    logic [AW-1:0]    seq_pc;
    logic [AW+DW-1:0] head;
    logic             ack_in;
    logic             push;
    logic             pop;
    logic             space_now;
    logic             space_after;

    assign ack_in = bus.imem_ack & (state != IDLE);
    assign pop    = bus.instr_valid & bus.instr_ready;
    // A redirect discards the returning word instead of queueing it.
    assign push   = (state == REQ) & ack_in & ~bus.redirect;

    assign space_now   = q_count < CW'(DEPTH);
    // Room left after this cycle's push (and possible pop): count+1-pop < DEPTH.
    assign space_after = (q_count - CW'(pop)) < CW'(DEPTH - 1);

`ifdef SISC_FETCH_BRPRED_EN
    assign seq_pc = is_uncond_bra(bus.imem_rdata[DW-1:DW-4], bus.imem_rdata[DW-5:DW-8])
                  ? fetch_pc + AW'(1) + bus.imem_rdata[AW-1:0]
                  : fetch_pc + AW'(1);
`else
    assign seq_pc = fetch_pc + AW'(1);
`endif

    assign bus.imem_req  = (state != IDLE);
    assign bus.imem_addr = addr_q;
    assign bus.instr_pc  = head[AW+DW-1:DW];
    assign bus.instr     = head[DW-1:0];
    assign bus.dbg_state = state;

    sisc_fetch_q #(
        .DEPTH (DEPTH),
        .W     (AW + DW)
    ) u_q (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.redirect),
        .push  (push),
        .wdata ({fetch_pc, bus.imem_rdata}),
        .pop   (pop),
        .rdata (head),
        .valid (bus.instr_valid),
        .count (q_count)
    );

    // Fetch FSM: next state, next fetch PC and next request address.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        addr_nxt     = addr_q;
        case (state)
            IDLE: begin
                if (bus.redirect) begin
                    fetch_pc_nxt = bus.redirect_addr;
                end else if (space_now) begin
                    state_nxt = REQ;
                    addr_nxt  = fetch_pc;
                end
            end
            REQ: begin
                if (bus.redirect) begin
                    fetch_pc_nxt = bus.redirect_addr;
                    if (ack_in) begin
                        addr_nxt = bus.redirect_addr;
                    end else begin
                        state_nxt = DROP;
                    end
                end else if (ack_in) begin
                    fetch_pc_nxt = seq_pc;
                    if (space_after) addr_nxt  = seq_pc;
                    else             state_nxt = IDLE;
                end
            end
            DROP: begin
                if (bus.redirect) begin
                    fetch_pc_nxt = bus.redirect_addr;
                    // The stale read completes now, so start the new one.
                    if (ack_in) begin
                        state_nxt = REQ;
                        addr_nxt  = bus.redirect_addr;
                    end
                end else if (ack_in) begin
                    if (space_now) begin
                        state_nxt = REQ;
                        addr_nxt  = fetch_pc;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, fetch PC and request address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RST_VEC;
            addr_q   <= RST_VEC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            addr_q   <= addr_nxt;
        end
    end
endmodule

// File: doc/sisc_fetch.md
Name: sisc_fetch

Overview:
- Parametrised instruction-fetch front end for the SISC core; successor to the discrete pc/ir/br fetch path.
- Issues word reads to instruction memory over a req/ack handshake and buffers returned words with their PCs in a DEPTH-entry prefetch queue.
- Presents instructions to decode/ctrl over a valid/ready interface.
- Supports redirect (taken branch/jump) with queue flush and discard of an in-flight response.

Parameters:
- AW, 16, PC/instruction-address width in words.
- DW, 32, instruction width.
- DEPTH, 4, prefetch queue entries; power of two, minimum 2.
- RST_VEC, 0, PC loaded on reset (AW bits).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  memory read request.
- imem_addr  out  AW  word address; stable while imem_req=1.
- imem_ack  in  1  read-data-valid strobe; sampled only while imem_req=1.
- imem_rdata  in  DW  read data, valid in the imem_ack cycle.
- instr_valid  out  1  queue head valid.
- instr  out  DW  queue-head instruction.
- instr_pc  out  AW  PC of the queue-head instruction.
- instr_ready  in  1  decode consumes head when instr_valid & instr_ready.
- redirect  in  1  one-cycle flush-and-restart strobe.
- redirect_addr  in  AW  new fetch PC, sampled when redirect=1.
- q_count  out  $clog2(DEPTH)+1  current queue occupancy.

Behaviour:
- Reset (rst=1 at posedge):
  - fetch_pc=RST_VEC; queue empty.
  - q_count=0, instr_valid=0, imem_req=0, imem_addr=RST_VEC.
  - FSM returns to IDLE, including mid-transaction; a later ack is ignored because req=0.
- FSM states: IDLE, REQ, DROP.
  - IDLE: if q_count<DEPTH and no redirect, then next cycle imem_req=1, imem_addr=fetch_pc, state REQ.
  - REQ: hold req and address until ack. On ack, write {fetch_pc, imem_rdata} to the queue tail and set fetch_pc=fetch_pc+1 (mod 2^AW).
    - If the queue still has space after that write, stay in REQ and drive the new address back-to-back with no bubble; otherwise go to IDLE.
  - DROP: entered on redirect while in REQ without ack. Hold req/address until ack, discard the data, then go to IDLE (or REQ with redirect_addr if space).
- At most one outstanding request. A request is never issued unless a slot is free at issue time, so the queue never overflows.
- Queue is a FIFO with registered head outputs.
  - Latency from ack to instr_valid: 1 cycle.
  - Simultaneous push and pop: q_count unchanged.
  - Pop while empty: no effect.
  - Pointer wrap is modulo DEPTH.
- Redirect (highest priority) at a posedge:
  - Queue flushed: q_count=0, instr_valid=0 next cycle.
  - fetch_pc=redirect_addr.
  - A concurrent pop or ack-push is discarded.
  - Redirect coincident with ack: no DROP; data discarded; new request at redirect_addr the next cycle.
  - Redirect in DROP: update fetch_pc, stay in DROP.
- PC arithmetic is unsigned AW-bit, wraps 2^AW-1 -> 0.
- instr, instr_pc hold their last values when instr_valid=0; the bench must not check them in that state.

Optional Feature:
- Macro SISC_FETCH_BRPRED_EN.
- Defined: static predecode on capture.
  - Applies when imem_rdata[DW-1:DW-4]==OP_BRA and [DW-5:DW-8]==4'h0 (unconditional relative branch).
  - Next fetch_pc = captured PC + 1 + imem_rdata[AW-1:0] (mod 2^AW) instead of PC+1.
  - The entry is still enqueued; ctrl does not redirect on it.
- Undefined: always PC+1; predecode logic absent.

Decomposition:
- Package sisc_pkg:
  - opcode constants OP_BRA and the other major opcodes.
  - fetch FSM state typedef {IDLE, REQ, DROP}.
  - queue-entry struct {pc, instr}.
- One sub-module: sisc_fetch_q, a parametrised synchronous FIFO with DEPTH, width AW+DW, flush input, and count output.
- FSM and PC logic stay in sisc_fetch.

Test Plan:
- Reset with RST_VEC=16'h0010, ack returned 1 cycle after each req, instr_ready=1:
  - Required: addresses 0x0010, 0x0011, 0x0012 back-to-back.
  - Required: instr_pc follows the same sequence, with instr equal to the returned data.
- instr_ready=0, DEPTH=4:
  - Required: exactly 4 requests, q_count=4, imem_req=0.
  - Then one pop: required one new request at the next sequential address.
- Redirect to 0x0100 while a req to 0x0013 is awaiting ack, ack returned 3 cycles later with 0xDEADBEEF:
  - Required: 0xDEADBEEF never appears on instr.
  - Required: next request at 0x0100; q_count=0 right after the redirect.
- Redirect in the same cycle as ack and as a pop:
  - Required: queue empty next cycle.
  - Required: req at redirect_addr the following cycle.
- fetch_pc=16'hFFFF:
  - Required: fetches 0xFFFF, then 0x0000.
- With SISC_FETCH_BRPRED_EN, word at 0x0020 = {OP_BRA, 4'h0, 8'h00, 16'h0005}:
  - Required: next request at 0x0026.
  - Without the macro: 0x0021.
